// File: rtl/sap_pkg.sv
// SAP-1 controller shared definitions: opcodes, FSM state encoding and
// control-word bit positions. Optional macro SAP_CTRL_JMP_EN adds the
// pc_load control bit used by the JMP instruction.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T1     = 3'd1,
        S_T2     = 3'd2,
        S_T3     = 3'd3,
        S_T4     = 3'd4,
        S_T5     = 3'd5,
        S_T6     = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    // Control word bits are active-high internally; the top inverts the
    // active-low strobes at the ports.
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_ACC_LOAD = 6;
    localparam int CW_ACC_OUT  = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_OUT  = 10;
    localparam int CW_OUT_LOAD = 11;
`ifdef SAP_CTRL_JMP_EN
    localparam int CW_PC_LOAD  = 12;
    localparam int CW_W        = 13;
`else
    localparam int CW_W        = 12;
`endif

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational microcode decode: (T-state, latched opcode) -> control word.
// Optional macro SAP_CTRL_JMP_EN enables the JMP (4'h7) microcode.
module sap_ctrl_decode
    import sap_pkg::*;
(
    input  logic [2:0]      state,
    input  logic [3:0]      opcode,
    output logic [CW_W-1:0] cw
);

    state_t st;
    assign st = state_t'(state);

    // Fetch steps are opcode-independent; execute steps depend on the opcode.
    always_comb begin
        cw = '0;
        case (st)
            S_T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            S_T2: begin
                cw[CW_PC_INC]   = 1'b1;
            end
            S_T3: begin
                cw[CW_RAM_OUT]  = 1'b1;
                cw[CW_IR_LOAD]  = 1'b1;
            end
            S_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_ACC_OUT]  = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
`ifdef SAP_CTRL_JMP_EN
                    OP_JMP: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_PC_LOAD]  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT]  = 1'b1;
                        cw[CW_ACC_LOAD] = 1'b1;
                    end
                    OP_ADD: begin
                        cw[CW_RAM_OUT]  = 1'b1;
                        cw[CW_B_LOAD]   = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_RAM_OUT]  = 1'b1;
                        cw[CW_B_LOAD]   = 1'b1;
                        cw[CW_ALU_SUB]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_ADD: begin
                        cw[CW_ALU_OUT]  = 1'b1;
                        cw[CW_ACC_LOAD] = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_ALU_OUT]  = 1'b1;
                        cw[CW_ACC_LOAD] = 1'b1;
                        cw[CW_ALU_SUB]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 ring-counter controller: IDLE/T1..T6/HALTED FSM plus opcode latch.
// All outputs decode from registered state and registered opcode only.
// Optional macro SAP_CTRL_JMP_EN adds pc_load_bar and the JMP instruction.
module sap_controller
    import sap_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] instruction_in,
    output logic       pc_inc,
    output logic       pc_out_bar,
    output logic       mar_load_bar,
    output logic       ram_out_bar,
    output logic       ir_load_bar,
    output logic       ir_out_bar,
    output logic       acc_load_bar,
    output logic       acc_out_bar,
    output logic       b_load_bar,
    output logic       alu_sub,
    output logic       alu_out_bar,
    output logic       out_load_bar,
`ifdef SAP_CTRL_JMP_EN
    output logic       pc_load_bar,
`endif
    output logic [5:0] t_state,
    output logic       halted
);

    state_t          state_q;
    logic [3:0]      opcode_q;
    logic [CW_W-1:0] cw;
    logic            run_eff;

    assign run_eff = AUTO_RUN | run;

    // Step the ring counter; run only matters in IDLE and at the end of T6.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= run_eff ? S_T1 : S_IDLE;
                S_T1:     state_q <= S_T2;
                S_T2:     state_q <= S_T3;
                S_T3: begin
                    state_q  <= S_T4;
                    opcode_q <= instruction_in;
                end
                S_T4:     state_q <= (opcode_q == OP_HLT) ? S_HALTED : S_T5;
                S_T5:     state_q <= S_T6;
                S_T6:     state_q <= run_eff ? S_T1 : S_IDLE;
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    sap_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (opcode_q),
        .cw     (cw)
    );

    assign pc_inc       =  cw[CW_PC_INC];
    assign pc_out_bar   = ~cw[CW_PC_OUT];
    assign mar_load_bar = ~cw[CW_MAR_LOAD];
    assign ram_out_bar  = ~cw[CW_RAM_OUT];
    assign ir_load_bar  = ~cw[CW_IR_LOAD];
    assign ir_out_bar   = ~cw[CW_IR_OUT];
    assign acc_load_bar = ~cw[CW_ACC_LOAD];
    assign acc_out_bar  = ~cw[CW_ACC_OUT];
    assign b_load_bar   = ~cw[CW_B_LOAD];
    assign alu_sub      =  cw[CW_ALU_SUB];
    assign alu_out_bar  = ~cw[CW_ALU_OUT];
    assign out_load_bar = ~cw[CW_OUT_LOAD];
`ifdef SAP_CTRL_JMP_EN
    assign pc_load_bar  = ~cw[CW_PC_LOAD];
`endif

    assign halted = (state_q == S_HALTED);

    // One-hot T-state indicator, zero outside T1..T6.
    always_comb begin
        t_state = 6'b000000;
        case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: stimulus pushes the expected state
// for each coming cycle, a negedge monitor pops and compares.
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] instruction_in;
    logic       pc_inc, pc_out_bar, mar_load_bar, ram_out_bar, ir_load_bar;
    logic       ir_out_bar, acc_load_bar, acc_out_bar, b_load_bar, alu_sub;
    logic       alu_out_bar, out_load_bar;
    logic       pc_load_act;
`ifdef SAP_CTRL_JMP_EN
    logic       pc_load_bar;
    assign pc_load_act = ~pc_load_bar;
`else
    assign pc_load_act = 1'b0;
`endif
    logic [5:0] t_state;
    logic       halted;

    sap_controller dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .instruction_in (instruction_in),
        .pc_inc         (pc_inc),
        .pc_out_bar     (pc_out_bar),
        .mar_load_bar   (mar_load_bar),
        .ram_out_bar    (ram_out_bar),
        .ir_load_bar    (ir_load_bar),
        .ir_out_bar     (ir_out_bar),
        .acc_load_bar   (acc_load_bar),
        .acc_out_bar    (acc_out_bar),
        .b_load_bar     (b_load_bar),
        .alu_sub        (alu_sub),
        .alu_out_bar    (alu_out_bar),
        .out_load_bar   (out_load_bar),
`ifdef SAP_CTRL_JMP_EN
        .pc_load_bar    (pc_load_bar),
`endif
        .t_state        (t_state),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Active-high view of the controls, MSB first.
    localparam logic [11:0] C_PCINC  = 12'h800;
    localparam logic [11:0] C_PCOUT  = 12'h400;
    localparam logic [11:0] C_MAR    = 12'h200;
    localparam logic [11:0] C_RAM    = 12'h100;
    localparam logic [11:0] C_IRL    = 12'h080;
    localparam logic [11:0] C_IROUT  = 12'h040;
    localparam logic [11:0] C_ACCL   = 12'h020;
    localparam logic [11:0] C_ACCOUT = 12'h010;
    localparam logic [11:0] C_BL     = 12'h008;
    localparam logic [11:0] C_SUB    = 12'h004;
    localparam logic [11:0] C_ALUOUT = 12'h002;
    localparam logic [11:0] C_OUTL   = 12'h001;

    logic [11:0] act;
    assign act = {pc_inc, ~pc_out_bar, ~mar_load_bar, ~ram_out_bar, ~ir_load_bar,
                  ~ir_out_bar, ~acc_load_bar, ~acc_out_bar, ~b_load_bar, alu_sub,
                  ~alu_out_bar, ~out_load_bar};

    typedef struct {
        int         cyc;
        logic [5:0] ts;
        logic       h;
        logic [11:0] c;
        logic       pl;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        int nbus;
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            e = q.pop_front();
            total++;
            if (e.cyc != cycle) begin
                bad++;
                $display("FAIL missed_slot cyc=%0d expected_at=%0d", cycle, e.cyc);
            end else begin
                if (t_state !== e.ts) begin
                    bad++;
                    $display("FAIL t_state cyc=%0d got=%b exp=%b", cycle, t_state, e.ts);
                end
                total++;
                if (halted !== e.h) begin
                    bad++;
                    $display("FAIL halted cyc=%0d got=%b exp=%b", cycle, halted, e.h);
                end
                total++;
                if (act !== e.c) begin
                    bad++;
                    $display("FAIL controls cyc=%0d got=%h exp=%h", cycle, act, e.c);
                end
                total++;
                if (pc_load_act !== e.pl) begin
                    bad++;
                    $display("FAIL pc_load cyc=%0d got=%b exp=%b", cycle, pc_load_act, e.pl);
                end
                nbus = int'(~pc_out_bar) + int'(~ram_out_bar) + int'(~ir_out_bar)
                     + int'(~acc_out_bar) + int'(~alu_out_bar);
                total++;
                if (nbus > 1) begin
                    bad++;
                    $display("FAIL bus_contention cyc=%0d drivers=%0d max=1", cycle, nbus);
                end
            end
        end
    end

    // Drive inputs for the coming edge and record the state expected after it.
    task automatic cyc(input logic r, input logic rs, input logic [3:0] ins,
                       input int t, input logic h, input logic [11:0] c,
                       input logic pl = 1'b0);
        exp_t e;
        run            = r;
        rst            = rs;
        instruction_in = ins;
        e.cyc = cycle + 1;
        e.ts  = (t == 0) ? 6'b000000 : 6'(1 << (t - 1));
        e.h   = h;
        e.c   = c;
        e.pl  = pl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch: run=1 leaves IDLE/T6, then run=0 during T2/T3 must be ignored.
    task automatic fetch(input logic [3:0] op);
        cyc(1'b1, 1'b0, op, 1, 1'b0, C_PCOUT | C_MAR);
        cyc(1'b0, 1'b0, op, 2, 1'b0, C_PCINC);
        cyc(1'b0, 1'b0, op, 3, 1'b0, C_RAM | C_IRL);
    endtask

    initial begin
        // Reset and idle hold.
        cyc(1'b1, 1'b1, 4'h0, 0, 1'b0, 12'h000);
        cyc(1'b0, 1'b1, 4'h0, 0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h0, 0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h0, 0, 1'b0, 12'h000);

        // LDA; run pulsed in T5 has no effect.
        fetch(4'h0);
        cyc(1'b0, 1'b0, 4'h0, 4, 1'b0, C_IROUT | C_MAR);
        cyc(1'b1, 1'b0, 4'h0, 5, 1'b0, C_RAM | C_ACCL);
        cyc(1'b0, 1'b0, 4'h0, 6, 1'b0, 12'h000);

        // ADD; instruction_in changes while in T5, T6 still decodes ADD.
        fetch(4'h1);
        cyc(1'b0, 1'b0, 4'h1, 4, 1'b0, C_IROUT | C_MAR);
        cyc(1'b0, 1'b0, 4'h1, 5, 1'b0, C_RAM | C_BL);
        cyc(1'b0, 1'b0, 4'h2, 6, 1'b0, C_ALUOUT | C_ACCL);

        // SUB; run=0 at the end of T6 returns to IDLE.
        fetch(4'h2);
        cyc(1'b0, 1'b0, 4'h2, 4, 1'b0, C_IROUT | C_MAR);
        cyc(1'b0, 1'b0, 4'h2, 5, 1'b0, C_RAM | C_BL | C_SUB);
        cyc(1'b0, 1'b0, 4'h2, 6, 1'b0, C_ALUOUT | C_ACCL | C_SUB);
        cyc(1'b0, 1'b0, 4'h2, 0, 1'b0, 12'h000);

        // OUT.
        fetch(4'hE);
        cyc(1'b0, 1'b0, 4'hE, 4, 1'b0, C_ACCOUT | C_OUTL);
        cyc(1'b0, 1'b0, 4'hE, 5, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'hE, 6, 1'b0, 12'h000);

        // Undefined opcode behaves as NOP.
        fetch(4'h5);
        cyc(1'b0, 1'b0, 4'h5, 4, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h5, 5, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h5, 6, 1'b0, 12'h000);

        // 4'h7: JMP when enabled, NOP otherwise.
        fetch(4'h7);
`ifdef SAP_CTRL_JMP_EN
        cyc(1'b0, 1'b0, 4'h7, 4, 1'b0, C_IROUT, 1'b1);
`else
        cyc(1'b0, 1'b0, 4'h7, 4, 1'b0, 12'h000);
`endif
        cyc(1'b0, 1'b0, 4'h7, 5, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h7, 6, 1'b0, 12'h000);

        // ADD with reset asserted during T5, run held high.
        fetch(4'h1);
        cyc(1'b0, 1'b0, 4'h1, 4, 1'b0, C_IROUT | C_MAR);
        cyc(1'b1, 1'b0, 4'h1, 5, 1'b0, C_RAM | C_BL);
        cyc(1'b1, 1'b1, 4'h1, 0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h1, 0, 1'b0, 12'h000);

        // HLT: halted after T4, run toggling ignored, reset recovers.
        fetch(4'hF);
        cyc(1'b1, 1'b0, 4'hF, 4, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 4'hF, 0, 1'b1, 12'h000);
        for (int i = 0; i < 20; i++)
            cyc(logic'(i[0]), 1'b0, 4'hF, 0, 1'b1, 12'h000);
        cyc(1'b1, 1'b1, 4'hF, 0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 4'h0, 0, 1'b0, 12'h000);

        // Restart after reset.
        fetch(4'h0);

        done = 1'b1;
    end

    // Finish once stimulus is done and the scoreboard has drained, or on timeout.
    initial begin
        int waited;
        waited = 0;
        while (!done && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (!done || q.size() != 0) begin
            bad++;
            $display("FAIL drain done=%0d left=%0d exp_left=0", done, q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL provide parameter AUTO_RUN, default 0; when 1, the run input is ignored and treated as constant 1.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port run  input  1  start/continue request, sampled at instruction boundaries.
REQ-005 SHALL have port instruction_in  input  4  opcode from instruction register output.
REQ-006 SHALL have port pc_inc  output  1  program counter increment enable, active-high.
REQ-007 SHALL have port pc_out_bar  output  1  PC drives bus, active-low.
REQ-008 SHALL have port mar_load_bar  output  1  MAR load, active-low.
REQ-009 SHALL have port ram_out_bar  output  1  RAM drives bus, active-low.
REQ-010 SHALL have port ir_load_bar  output  1  instruction register load, active-low.
REQ-011 SHALL have port ir_out_bar  output  1  instruction register operand drives bus, active-low.
REQ-012 SHALL have port acc_load_bar  output  1  accumulator load, active-low.
REQ-013 SHALL have port acc_out_bar  output  1  accumulator drives bus, active-low.
REQ-014 SHALL have port b_load_bar  output  1  B register load, active-low.
REQ-015 SHALL have port alu_sub  output  1  ALU subtract select, active-high.
REQ-016 SHALL have port alu_out_bar  output  1  ALU drives bus, active-low.
REQ-017 SHALL have port out_load_bar  output  1  output register load, active-low.
REQ-018 SHALL have port t_state  output  6  one-hot T1..T6 (bit0=T1); all-zero in IDLE/HALTED.
REQ-019 SHALL have port halted  output  1  high while in HALTED.

Function
REQ-020 SHALL implement states IDLE, T1..T6, HALTED; all outputs decoded from registered state and registered opcode only (no combinational input-to-output path).
REQ-021 IDLE->T1 when run=1; T1->T2->T3->T4->T5->T6 unconditionally; T6->T1 if run=1, else IDLE.
REQ-022 run changes during T1..T5 SHALL have no effect.
REQ-023 SHALL capture instruction_in into opcode_q on the T3->T4 edge; opcode_q is stable through T4..T6.
REQ-024 Fetch: T1 pc_out_bar=0, mar_load_bar=0; T2 pc_inc=1; T3 ram_out_bar=0, ir_load_bar=0.
REQ-025 LDA (4'h0): T4 ir_out_bar=0, mar_load_bar=0; T5 ram_out_bar=0, acc_load_bar=0; T6 none.
REQ-026 ADD (4'h1): T4 as LDA; T5 ram_out_bar=0, b_load_bar=0; T6 alu_out_bar=0, acc_load_bar=0.
REQ-027 SUB (4'h2): as ADD, with alu_sub=1 in T5 and T6.
REQ-028 OUT (4'hE): T4 acc_out_bar=0, out_load_bar=0; T5, T6 none.
REQ-029 HLT (4'hF): in T4 all controls inactive; T4->HALTED; HALTED persists regardless of run until rst.
REQ-030 Any other opcode SHALL execute as NOP (T4..T6 all controls inactive) and continue normally.
REQ-031 Inactive levels: every *_bar output =1; pc_inc=0; alu_sub=0. At most one bus driver (*_out_bar) SHALL be low in any state.

Reset
REQ-032 rst=1 at any edge, including mid-instruction or in HALTED, SHALL force IDLE, opcode_q=4'h0, t_state=0, halted=0, all controls inactive on the next cycle.
REQ-033 rst SHALL take priority over run and over all state transitions.

Configuration
REQ-034 Macro SAP_CTRL_JMP_EN: when defined, SHALL add output pc_load_bar (1, active-low) and JMP opcode 4'h7 = T4 ir_out_bar=0, pc_load_bar=0; T5, T6 none.
REQ-035 Without SAP_CTRL_JMP_EN, the pc_load_bar port SHALL be absent and 4'h7 SHALL execute as NOP.

Structure
REQ-036 Package sap_pkg SHALL hold opcode constants, the state encoding and the control-word bit positions.
REQ-037 Combinational control decode (state, opcode_q -> control word) SHALL be sub-module sap_ctrl_decode; the FSM and opcode register stay in sap_controller.

Verification
REQ-038 rst then run=1 with LDA -> T1..T6 one-hot sequence; T5 ram_out_bar=0 and acc_load_bar=0; back to T1.
REQ-039 SUB opcode 4'h2 -> alu_sub=1 exactly in T5, T6; alu_out_bar=0 and acc_load_bar=0 only in T6.
REQ-040 HLT 4'hF -> halted=1 from cycle after T4; run toggling ignored for 20 cycles; rst -> IDLE, halted=0.
REQ-041 run=0 asserted during T3 -> instruction completes, IDLE after T6; run=1 -> T1 next cycle.
REQ-042 rst pulsed in T5 of ADD -> next cycle IDLE, all *_bar=1, pc_inc=0; instruction_in changed in T5 does not alter T6 decode.
REQ-043 Opcode 4'h7 -> with SAP_CTRL_JMP_EN, pc_load_bar=0 in T4; without it, no control active in T4..T6.
